// File: rtl/amci_arbiter_pkg.sv
// amci_arbiter_pkg
//   Shared definitions for the AMCI arbiter: FSM state encoding, state width
//   and a helper that sizes the client index.
//   No ports (package).
package amci_arbiter_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  // Index width for n clients, never less than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/amci_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker. The search starts at ptr+1 (mod N) and
//   the first set request wins.
//   Ports:
//     req  in  N   request vector
//     ptr  in  IW  index of the most recently served client
//     gnt  out N   one-hot grant
//     idx  out IW  binary index of the granted client
//     any  out 1   at least one request is set
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int c;
    c   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 1; i <= N; i++) begin
      c = (int'(ptr) + i) % N;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/amci_arbiter.sv
// amci_arbiter
//   Shares one AXI4-Lite master's AMCI user interface between NUM_CLIENTS
//   register-access clients. One transaction in flight at a time, round-robin
//   grant, one-cycle one-hot ACK per completed transaction.
//   Optional watchdog: define AMCI_ARB_TIMEOUT_EN to add the WAIT timeout,
//   the DRAIN state and the ERR output.
//   Ports:
//     M_AXI_ACLK, RESETN           clock, synchronous active-low reset
//     REQ/REQ_WR                   per-client request level and direction
//     REQ_ADDR/REQ_WDATA           flattened per-client address / write data
//     ACK, RDATA                   completion pulse, read result (held)
//     AMCI_WADDR/WDATA/WRITE/WIDLE write side of the master
//     AMCI_RADDR/READ/RIDLE/RDATA  read side of the master
//     ERR                          timeout flag with ACK (feature only)
//
//   state  | meaning
//   IDLE   | wait for a request with both master sides idle, then grant
//   ISSUE  | one-cycle AMCI_WRITE or AMCI_READ pulse
//   WAIT   | first cycle skipped, then wait for the relevant idle
//   DONE   | ACK high, advance round-robin pointer
//   DRAIN  | after a timeout, wait for the master to go idle
module amci_arbiter
  import amci_arbiter_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int NUM_CLIENTS      = 2,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                                    M_AXI_ACLK,
  input  logic                                    RESETN,
  input  logic [NUM_CLIENTS-1:0]                  REQ,
  input  logic [NUM_CLIENTS-1:0]                  REQ_WR,
  input  logic [NUM_CLIENTS*C_AXI_ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [NUM_CLIENTS*C_AXI_DATA_WIDTH-1:0] REQ_WDATA,
  output logic [NUM_CLIENTS-1:0]                  ACK,
  output logic [C_AXI_DATA_WIDTH-1:0]             RDATA,
  output logic [C_AXI_ADDR_WIDTH-1:0]             AMCI_WADDR,
  output logic [C_AXI_DATA_WIDTH-1:0]             AMCI_WDATA,
  output logic                                    AMCI_WRITE,
  input  logic                                    AMCI_WIDLE,
  output logic [C_AXI_ADDR_WIDTH-1:0]             AMCI_RADDR,
  output logic                                    AMCI_READ,
  input  logic                                    AMCI_RIDLE,
  input  logic [C_AXI_DATA_WIDTH-1:0]             AMCI_RDATA
`ifdef AMCI_ARB_TIMEOUT_EN
  ,
  output logic                                    ERR
`endif
);

  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int N  = NUM_CLIENTS;
  localparam int CLIENT_IDX_W = idx_width(NUM_CLIENTS);

  if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("amci_arbiter: NUM_CLIENTS must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  state_e                  state_q, state_d;
  logic [CLIENT_IDX_W-1:0] gidx_q, gidx_d;
  logic                    gwr_q, gwr_d;
  logic [CLIENT_IDX_W-1:0] ptr_q, ptr_d;
  logic                    first_q, first_d;
  logic [N-1:0]            ack_q, ack_d;
  logic [DW-1:0]           rdata_q, rdata_d;
  logic [AW-1:0]           waddr_q, waddr_d;
  logic [DW-1:0]           wdata_q, wdata_d;
  logic [AW-1:0]           raddr_q, raddr_d;
  logic                    write_q, write_d;
  logic                    read_q, read_d;
`ifdef AMCI_ARB_TIMEOUT_EN
  logic [31:0]             wd_q, wd_d;
  logic                    err_q, err_d;
  logic                    timeout_hit;
`endif

  logic [N-1:0]            arb_gnt;
  logic [CLIENT_IDX_W-1:0] arb_idx;
  logic                    arb_any;
  logic                    can_grant;
  logic                    wait_done;

  rr_arbiter #(
    .N  (N),
    .IW (CLIENT_IDX_W)
  ) u_rr (
    .req (REQ),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign can_grant = arb_any && AMCI_WIDLE && AMCI_RIDLE;

  // first_q masks the first WAIT cycle: the master's idle may not have
  // dropped yet in response to the pulse.
  assign wait_done = (state_q == ST_WAIT) && !first_q &&
                     (gwr_q ? AMCI_WIDLE : AMCI_RIDLE);

`ifdef AMCI_ARB_TIMEOUT_EN
  // wd_q holds the 1-based number of the current WAIT cycle.
  assign timeout_hit = (state_q == ST_WAIT) && !wait_done &&
                       (wd_q == 32'(TIMEOUT_CYCLES));
`endif

  always_ff @(posedge M_AXI_ACLK) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      gidx_q  <= '0;
      gwr_q   <= 1'b0;
      ptr_q   <= CLIENT_IDX_W'(N - 1);
      first_q <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
`ifdef AMCI_ARB_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      gwr_q   <= gwr_d;
      ptr_q   <= ptr_d;
      first_q <= first_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      raddr_q <= raddr_d;
      write_q <= write_d;
      read_q  <= read_d;
`ifdef AMCI_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (can_grant) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (wait_done) state_d = ST_DONE;
`ifdef AMCI_ARB_TIMEOUT_EN
        else if (timeout_hit) state_d = ST_DRAIN;
`endif
      end
      ST_DONE:  state_d = ST_IDLE;
`ifdef AMCI_ARB_TIMEOUT_EN
      ST_DRAIN: if (AMCI_WIDLE && AMCI_RIDLE) state_d = ST_IDLE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gidx_d  = gidx_q;
    gwr_d   = gwr_q;
    ptr_d   = ptr_q;
    first_d = first_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    raddr_d = raddr_q;
    write_d = 1'b0;
    read_d  = 1'b0;
`ifdef AMCI_ARB_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (can_grant) begin
          gidx_d = arb_idx;
          gwr_d  = |(REQ_WR & arb_gnt);
          if (gwr_d) begin
            waddr_d = REQ_ADDR[int'(arb_idx)*AW +: AW];
            wdata_d = REQ_WDATA[int'(arb_idx)*DW +: DW];
            write_d = 1'b1;
          end else begin
            raddr_d = REQ_ADDR[int'(arb_idx)*AW +: AW];
            read_d  = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        first_d = 1'b1;
`ifdef AMCI_ARB_TIMEOUT_EN
        wd_d    = 32'd1;
`endif
      end
      ST_WAIT: begin
        first_d = 1'b0;
`ifdef AMCI_ARB_TIMEOUT_EN
        wd_d    = wd_q + 32'd1;
`endif
        if (wait_done) begin
          ack_d[gidx_q] = 1'b1;
          if (!gwr_q) rdata_d = AMCI_RDATA;
        end
`ifdef AMCI_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          // RDATA deliberately left alone: the read never completed.
          ack_d[gidx_q] = 1'b1;
          err_d         = 1'b1;
          ptr_d         = gidx_q;
        end
`endif
      end
      ST_DONE: ptr_d = gidx_q;
      default: ;
    endcase
  end

  assign ACK        = ack_q;
  assign RDATA      = rdata_q;
  assign AMCI_WADDR = waddr_q;
  assign AMCI_WDATA = wdata_q;
  assign AMCI_WRITE = write_q;
  assign AMCI_RADDR = raddr_q;
  assign AMCI_READ  = read_q;
`ifdef AMCI_ARB_TIMEOUT_EN
  assign ERR        = err_q;
`endif

endmodule
